// File: rtl/ptlrx_toggle_monitor.sv
// Capture stage for the PTL receiver toggle line: synchronize, edge-detect,
// timestamp, count, spacing-check, and buffer events in a small FWFT FIFO.
module ptlrx_toggle_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TS_W        = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             en,
  input  logic             clr,
  output logic             pulse_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic             evt_err,
  output logic [CNT_W-1:0] pulse_count,
  output logic             gap_violation,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   primed_q, primed_d;
  logic                   base_q, base_d;
  logic                   pulse_q, pulse_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   first_q, first_d;
  logic                   gviol_q, gviol_d;
  logic                   ovf_q, ovf_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0][TS_W-1:0] ts_mem_q, ts_mem_d;
  logic [FIFO_DEPTH-1:0]           err_mem_q, err_mem_d;

  logic s, err, empty, full, push, pop, push_ok;

  assign s     = sync_q[SYNC_STAGES-1];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push    = pulse_q & en;
  assign pop     = ~empty & evt_ready;
  assign push_ok = push & (~full | pop);
  // The first pulse after reset/clr has no predecessor to be too close to.
  assign err     = pulse_q & ~first_q & (gap_q < GW'(MIN_GAP));

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], q_in};
    fill_d    = fill_q;
    primed_d  = primed_q;
    base_d    = base_q;
    pulse_d   = 1'b0;
    ts_d      = ts_q + TS_W'(1);
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    first_d   = first_q;
    gviol_d   = gviol_q | err;
    ovf_d     = ovf_q | (push & full & ~pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ts_mem_d  = ts_mem_q;
    err_mem_d = err_mem_q;

    // Baseline is taken only once the synchronizer holds real samples, so a
    // line already high at reset release does not look like a toggle.
    if (!primed_q) begin
      if (fill_q == FW'(SYNC_STAGES)) begin
        base_d   = s;
        primed_d = 1'b1;
      end else begin
        fill_d = fill_q + FW'(1);
      end
    end else begin
      pulse_d = s ^ base_q;
      base_d  = s;
    end

    if (pulse_q) begin
      gap_d   = GW'(1);
      first_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (gap_q < GW'(MIN_GAP)) begin
      gap_d = gap_q + GW'(1);
    end

    if (push_ok) begin
      ts_mem_d[wr_ptr_q[AW-1:0]]  = ts_q;
      err_mem_d[wr_ptr_q[AW-1:0]] = err;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);

    // FIFO push above still uses the pre-clear ts; only the bookkeeping clears.
    if (clr) begin
      ts_d    = '0;
      cnt_d   = '0;
      gap_d   = '0;
      first_d = 1'b1;
      gviol_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      fill_q    <= '0;
      primed_q  <= 1'b0;
      base_q    <= 1'b0;
      pulse_q   <= 1'b0;
      ts_q      <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      first_q   <= 1'b1;
      gviol_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ts_mem_q  <= '0;
      err_mem_q <= '0;
    end else begin
      sync_q    <= sync_d;
      fill_q    <= fill_d;
      primed_q  <= primed_d;
      base_q    <= base_d;
      pulse_q   <= pulse_d;
      ts_q      <= ts_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      first_q   <= first_d;
      gviol_q   <= gviol_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ts_mem_q  <= ts_mem_d;
      err_mem_q <= err_mem_d;
    end
  end

  assign pulse_out     = pulse_q;
  assign evt_valid     = ~empty;
  assign evt_ts        = ts_mem_q[rd_ptr_q[AW-1:0]];
  assign evt_err       = err_mem_q[rd_ptr_q[AW-1:0]];
  assign pulse_count   = cnt_q;
  assign gap_violation = gviol_q;
  assign overflow      = ovf_q;

endmodule
